// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: branch/jump opcodes and the hazard FSM state type.
package dlx_pkg;

    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JR   = 6'h12;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Saturating 16-bit event counter step.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic is_cti_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNEZ) || (op == OP_J) || (op == OP_JR);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Register-compare logic between the EX destination and the ID sources;
// produces the number of bubble cycles the ID instruction needs.
module hazard_cmp (
    input  logic       ex_memread,
    input  logic       ex_regwrite,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       id_branch,
    input  logic       id_branch_ne,
    input  logic       id_jr,
    output logic [1:0] stall_len
);

    logic dep1;
    logic dep2;
    logic is_cti;

    assign dep1   = (ex_rd != 5'd0) && (ex_rd == id_rs1);
    assign dep2   = id_uses_rs2 && (ex_rd != 5'd0) && (ex_rd == id_rs2);
    assign is_cti = id_branch | id_branch_ne | id_jr;

    // ID-stage compare needs the load data, which arrives one cycle later than for ALU ops.
    always_comb begin
        stall_len = 2'd0;
        if (ex_memread && dep1 && is_cti) begin
            stall_len = 2'd2;
        end else if (ex_memread && (dep1 || dep2)) begin
            stall_len = 2'd1;
        end else if (ex_regwrite && !ex_memread && dep1 && is_cti) begin
            stall_len = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stalls ID on data hazards and issues one-cycle redirect
// pulses for taken branches/jumps, with saturating event counters.
//
// state    | meaning
// RUN      | evaluate ID instruction for stall / taken
// STALL    | holding pipeline; counter>0 bubbles, counter==0 re-evaluates ID
// REDIRECT | check pulse active, ID instruction is flushed and ignored
module hazard_ctrl
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_branch,
    input  logic        id_branch_ne,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic        id_uses_rs2,
    input  logic        id_cmp_eq,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    output logic        branchCheck,
    output logic        JumpCheck,
    output logic        JRCheck,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  chk_q, chk_d;  // {jr, jump, branch}
    logic [1:0]  stall_len;
    logic        stall;
    logic        eval;
    logic        taken;
    logic [15:0] stall_cnt_q;
    logic [15:0] redirect_cnt_q;

    hazard_cmp u_cmp (
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .id_branch    (id_branch),
        .id_branch_ne (id_branch_ne),
        .id_jr        (id_jr),
        .stall_len    (stall_len)
    );

    assign taken = id_valid && ((id_branch && id_cmp_eq) || (id_branch_ne && !id_cmp_eq)
                                || id_jump || id_jr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chk_d   = 3'b000;
        stall   = 1'b0;
        eval    = 1'b0;
        case (state_q)
            RUN:      eval = 1'b1;
            STALL: begin
                if (cnt_q != 2'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    eval = 1'b1;
                end
            end
            REDIRECT: state_d = RUN;
            default:  state_d = RUN;
        endcase
        // Final stall cycle doubles as the RUN cycle that re-evaluates the held instruction.
        if (eval) begin
            state_d = RUN;
            if (id_valid && (stall_len != 2'd0)) begin
                stall   = 1'b1;
                state_d = STALL;
                cnt_d   = stall_len - 2'd1;
            end else if (taken) begin
                state_d = REDIRECT;
                if (id_jr) begin
                    chk_d = 3'b100;
                end else if (id_jump) begin
                    chk_d = 3'b010;
                end else begin
                    chk_d = 3'b001;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            chk_q          <= 3'b000;
            stall_cnt_q    <= 16'd0;
            redirect_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            if (stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (chk_q != 3'b000) begin
                redirect_cnt_q <= sat_inc(redirect_cnt_q);
            end
        end
    end

    assign bubble       = stall && !reset;
    assign pc_write     = !bubble;
    assign ifid_write   = !bubble;
    assign branchCheck  = chk_q[0] && !reset;
    assign JumpCheck    = chk_q[1] && !reset;
    assign JRCheck      = chk_q[2] && !reset;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked every cycle against a cycle-count model of the stall/redirect rules.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_branch, id_branch_ne, id_jump, id_jr, id_uses_rs2, id_cmp_eq;
    logic [4:0]  id_rs1, id_rs2;
    logic        ex_memread, ex_regwrite;
    logic [4:0]  ex_rd;
    logic        branchCheck, JumpCheck, JRCheck, pc_write, ifid_write, bubble;
    logic [15:0] stall_cnt, redirect_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_branch    (id_branch),
        .id_branch_ne (id_branch_ne),
        .id_jump      (id_jump),
        .id_jr        (id_jr),
        .id_uses_rs2  (id_uses_rs2),
        .id_cmp_eq    (id_cmp_eq),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .branchCheck  (branchCheck),
        .JumpCheck    (JumpCheck),
        .JRCheck      (JRCheck),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .bubble       (bubble),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    // Model: remaining bubble cycles, pending redirect flag, registered check pulse.
    int       m_left     = 0;
    bit       m_redirect = 1'b0;
    bit [2:0] m_chk      = 3'b000;  // {jr, jump, branch}
    int       m_scnt     = 0;
    int       m_rcnt     = 0;

    function automatic int m_n();
        bit dep1, dep2, cti;
        dep1 = (ex_rd != 0) && (ex_rd == id_rs1);
        dep2 = id_uses_rs2 && (ex_rd != 0) && (ex_rd == id_rs2);
        cti  = id_branch || id_branch_ne || id_jr;
        if (ex_memread && dep1 && cti) return 2;
        if (ex_memread && (dep1 || dep2)) return 1;
        if (ex_regwrite && !ex_memread && dep1 && cti) return 1;
        return 0;
    endfunction

    function automatic bit m_eval();
        return !m_redirect && (m_left == 0);
    endfunction

    function automatic bit m_stall();
        if (reset || m_redirect) return 1'b0;
        if (m_left > 0) return 1'b1;
        return id_valid && (m_n() > 0);
    endfunction

    function automatic bit m_taken();
        return !reset && m_eval() && id_valid && (m_n() == 0) &&
               ((id_branch && id_cmp_eq) || (id_branch_ne && !id_cmp_eq) || id_jump || id_jr);
    endfunction

    function automatic bit [2:0] m_kind();
        if (id_jr) return 3'b100;
        if (id_jump) return 3'b010;
        return 3'b001;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left     <= 0;
            m_redirect <= 1'b0;
            m_chk      <= 3'b000;
            m_scnt     <= 0;
            m_rcnt     <= 0;
        end else begin
            if (m_stall()) m_scnt <= (m_scnt >= 65535) ? 65535 : m_scnt + 1;
            if (m_chk != 3'b000) m_rcnt <= (m_rcnt >= 65535) ? 65535 : m_rcnt + 1;
            m_chk      <= 3'b000;
            m_redirect <= 1'b0;
            if (m_redirect) begin
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end else if (m_stall()) begin
                m_left <= m_n() - 1;
            end else if (m_taken()) begin
                m_redirect <= 1'b1;
                m_chk      <= m_kind();
            end
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit       st;
            bit [2:0] ck;
            st = m_stall();
            ck = reset ? 3'b000 : m_chk;
            cmp("model pc_write",     {15'd0, pc_write},    {15'd0, !st});
            cmp("model ifid_write",   {15'd0, ifid_write},  {15'd0, !st});
            cmp("model bubble",       {15'd0, bubble},      {15'd0, st});
            cmp("model checks",       {13'd0, JRCheck, JumpCheck, branchCheck}, {13'd0, ck});
            cmp("model stall_cnt",    stall_cnt,    m_scnt[15:0]);
            cmp("model redirect_cnt", redirect_cnt, m_rcnt[15:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_branch = 0; id_branch_ne = 0; id_jump = 0; id_jr = 0;
        id_uses_rs2 = 0; id_cmp_eq = 0; id_rs1 = 0; id_rs2 = 0;
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clr();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic beq_load_hazard();
        clr();
        id_valid = 1; id_branch = 1; id_cmp_eq = 1; id_rs1 = 3;
        ex_memread = 1; ex_rd = 3;
    endtask

    initial begin
        reset = 1;
        clr();
        tick();
        cmp_en = 1'b1;
        do_reset();
        @(negedge clk);
        cmp("reset pc_write", {15'd0, pc_write}, 16'd1);
        cmp("reset bubble",   {15'd0, bubble},   16'd0);
        cmp("reset stall_cnt", stall_cnt, 16'd0);

        // Load-use into ALU op on rs2: one bubble.
        tick();
        id_valid = 1; id_uses_rs2 = 1; id_rs2 = 5; ex_memread = 1; ex_rd = 5;
        @(negedge clk);
        cmp("lu bubble", {15'd0, bubble},   16'd1);
        cmp("lu pc_write", {15'd0, pc_write}, 16'd0);
        tick();
        ex_memread = 0; ex_rd = 0;
        @(negedge clk);
        cmp("lu release bubble", {15'd0, bubble},   16'd0);
        cmp("lu release pc_write", {15'd0, pc_write}, 16'd1);
        tick();
        clr();
        @(negedge clk);
        cmp("lu stall_cnt", stall_cnt, 16'd1);

        // Load into BEQ: two bubbles, then branchCheck.
        do_reset();
        beq_load_hazard();
        @(negedge clk);
        cmp("beq bubble1", {15'd0, bubble}, 16'd1);
        tick();
        @(negedge clk);
        cmp("beq bubble2", {15'd0, bubble}, 16'd1);
        tick();
        ex_memread = 0; ex_rd = 0;
        @(negedge clk);
        cmp("beq no bubble", {15'd0, bubble}, 16'd0);
        cmp("beq pulse early", {15'd0, branchCheck}, 16'd0);
        tick();
        id_valid = 0;
        @(negedge clk);
        cmp("beq branchCheck", {15'd0, branchCheck}, 16'd1);
        tick();
        @(negedge clk);
        cmp("beq pulse end", {15'd0, branchCheck}, 16'd0);
        cmp("beq redirect_cnt", redirect_cnt, 16'd1);
        cmp("beq stall_cnt", stall_cnt, 16'd2);

        // ALU into JR: one bubble, JRCheck, REDIRECT ignores a J in ID.
        do_reset();
        id_valid = 1; id_jr = 1; id_rs1 = 31; ex_regwrite = 1; ex_rd = 31;
        @(negedge clk);
        cmp("jr bubble", {15'd0, bubble}, 16'd1);
        tick();
        ex_regwrite = 0; ex_rd = 0;
        @(negedge clk);
        cmp("jr no bubble", {15'd0, bubble}, 16'd0);
        tick();
        id_jr = 0; id_jump = 1;
        @(negedge clk);
        cmp("jr JRCheck", {15'd0, JRCheck}, 16'd1);
        cmp("jr JumpCheck in redirect", {15'd0, JumpCheck}, 16'd0);
        tick();
        id_valid = 0;
        @(negedge clk);
        cmp("jr jump ignored", {14'd0, JumpCheck, JRCheck}, 16'd0);
        cmp("jr redirect_cnt", redirect_cnt, 16'd1);

        // r0 never creates a dependency; BNEZ with rs1==0 not taken.
        do_reset();
        id_valid = 1; id_branch_ne = 1; id_cmp_eq = 1; id_rs1 = 0; ex_memread = 1; ex_rd = 0;
        @(negedge clk);
        cmp("r0 bubble", {15'd0, bubble}, 16'd0);
        tick();
        clr();
        @(negedge clk);
        cmp("bnez no pulse", {15'd0, branchCheck}, 16'd0);

        // Reset during the second stall cycle.
        do_reset();
        beq_load_hazard();
        tick();
        reset = 1;
        @(negedge clk);
        cmp("rst mid bubble", {15'd0, bubble}, 16'd0);
        tick();
        reset = 0;
        clr();
        @(negedge clk);
        cmp("rst after pc_write", {15'd0, pc_write}, 16'd1);
        cmp("rst after checks", {13'd0, JRCheck, JumpCheck, branchCheck}, 16'd0);
        cmp("rst after stall_cnt", stall_cnt, 16'd0);
        cmp("rst after redirect_cnt", redirect_cnt, 16'd0);

        // Randomized traffic with a small register range to make dependencies common.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 79) == 0);
            id_valid     = ($urandom_range(0, 4) != 0);
            id_branch    = ($urandom_range(0, 3) == 0);
            id_branch_ne = ($urandom_range(0, 3) == 0);
            id_jump      = ($urandom_range(0, 5) == 0);
            id_jr        = ($urandom_range(0, 5) == 0);
            id_uses_rs2  = $urandom_range(0, 1) != 0;
            id_cmp_eq    = $urandom_range(0, 1) != 0;
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_memread   = ($urandom_range(0, 2) == 0);
            ex_regwrite  = $urandom_range(0, 1) != 0;
            ex_rd        = 5'($urandom_range(0, 3));
            tick();
        end

        // Continuous stall: counter must saturate.
        do_reset();
        beq_load_hazard();
        repeat (65540) tick();
        @(negedge clk);
        cmp("stall_cnt saturated", stall_cnt, 16'hFFFF);
        cmp("stall still bubble", {15'd0, bubble}, 16'd1);
        tick();
        clr();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
